// File: rtl/sr_cmd_conditioner_if.sv
// Request/pulse bundle between the raw request front-end and the SR flip-flop stage.
// The master drives the raw set/clear lines; the slave returns the conditioned pulses.
interface sr_cmd_conditioner_if;
    logic set_in;
    logic clr_in;
    logic S;
    logic R;
    logic busy;
    logic conflict;

    modport master (output set_in, clr_in, input S, R, busy, conflict);
    modport slave  (input set_in, clr_in, output S, R, busy, conflict);
endinterface

// File: rtl/sr_cmd_conditioner.sv
// Synchronises and debounces raw set/clear requests and turns each clean rising edge
// into a single, mutually exclusive, rate-limited S or R pulse for the SR stage.
module sr_cmd_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLDOFF_CYCLES  = 2,
    parameter int SET_PRIORITY    = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    sr_cmd_conditioner_if.slave        io_cmd
);
    localparam logic [7:0] DEB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] HOLD_LAST = 8'(HOLDOFF_CYCLES - 1);
    localparam logic       HOLD_NONE = (HOLDOFF_CYCLES == 0);
    localparam logic       SET_WINS  = (SET_PRIORITY != 0);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PULSE   = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    logic [1:0] w_raw;
    logic [1:0] w_rise;
    logic [1:0] w_serve;
    logic       w_can_launch;
    logic       w_pick_set;
    logic       w_pick_clr;

    state_t     r_state;
    logic [7:0] r_hold_cnt;
    logic [1:0] r_pend;
    logic       r_s_pulse;
    logic       r_r_pulse;
    logic       r_busy;
    logic       r_conflict;

    // Bit 0 is the set channel, bit 1 the clear channel throughout.
    assign w_raw = {io_cmd.clr_in, io_cmd.set_in};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            logic       r_meta;
            logic       r_sync;
            logic       r_deb;
            logic       r_deb_d;
            logic [7:0] r_cnt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_meta  <= 1'b0;
                    r_sync  <= 1'b0;
                    r_deb   <= 1'b0;
                    r_deb_d <= 1'b0;
                    r_cnt   <= 8'd0;
                end else begin
                    r_meta  <= w_raw[gi];
                    r_sync  <= r_meta;
                    r_deb_d <= r_deb;
                    if (r_sync == r_deb) begin
                        r_cnt <= 8'd0;
                    end else if (r_cnt == DEB_LAST) begin
                        r_deb <= ~r_deb;
                        r_cnt <= 8'd0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
            end

            assign w_rise[gi] = r_deb & ~r_deb_d;
        end
    endgenerate

    // A new pulse may start from IDLE or straight out of the last holdoff cycle,
    // so back-to-back requests are spaced exactly HOLDOFF_CYCLES+1 cycles apart.
    assign w_can_launch = (r_state == ST_IDLE)
                        | ((r_state == ST_PULSE) & HOLD_NONE)
                        | ((r_state == ST_HOLDOFF) & (r_hold_cnt == HOLD_LAST));

    assign w_pick_set = r_pend[0] & (SET_WINS | ~r_pend[1]);
    assign w_pick_clr = r_pend[1] & ~w_pick_set;
    assign w_serve    = w_can_launch ? {w_pick_clr, w_pick_set} : 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_hold_cnt <= 8'd0;
            r_pend     <= 2'b00;
            r_s_pulse  <= 1'b0;
            r_r_pulse  <= 1'b0;
            r_busy     <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            r_conflict <= &w_rise;
            // Edges arriving on the serve cycle survive: the flag is re-armed.
            r_pend     <= (r_pend & ~w_serve) | w_rise;
            r_s_pulse  <= w_serve[0];
            r_r_pulse  <= w_serve[1];
            if (|w_serve) begin
                r_state <= ST_PULSE;
                r_busy  <= 1'b1;
            end else begin
                case (r_state)
                    ST_PULSE: begin
                        if (HOLD_NONE) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state    <= ST_HOLDOFF;
                            r_hold_cnt <= 8'd0;
                        end
                    end
                    ST_HOLDOFF: begin
                        if (r_hold_cnt == HOLD_LAST) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + 8'd1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign io_cmd.S        = r_s_pulse;
    assign io_cmd.R        = r_r_pulse;
    assign io_cmd.busy     = r_busy;
    assign io_cmd.conflict = r_conflict;
endmodule
